// File: rtl/jk_cmd_sequencer.sv
// Two-requester round-robin command sequencer driving a bank of JK flip-flops.
// Optional Q read-back check is enabled by defining JK_SEQ_CHECK_EN.
module jk_cmd_sequencer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic             req0_valid_i,
   input  logic [1:0]       req0_op_i,
   input  logic [WIDTH-1:0] req0_mask_i,
   output logic             req0_ready_o,
   input  logic             req1_valid_i,
   input  logic [1:0]       req1_op_i,
   input  logic [WIDTH-1:0] req1_mask_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] q_i,
   output logic [WIDTH-1:0] j_o,
   output logic [WIDTH-1:0] k_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             done_id_o,
   output logic             err_o,
   output logic [7:0]       err_cnt_o
);

`ifdef JK_SEQ_CHECK_EN
   typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;
`else
   typedef enum logic [0:0] {StIdle, StDrive} state_e;
`endif

   state_e           state_q, state_d;
   logic             last_grant_q;
   logic             id_q;
   logic [WIDTH-1:0] j_q, k_q;
   logic             busy_q;
   logic             done_q, done_d;
   logic             done_id_q;

   logic             grant1;
   logic             idle;
   logic             hs;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_mask;

   // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
   always_comb begin
      idle         = (state_q == StIdle);
      grant1       = req1_valid_i & (~req0_valid_i | ~last_grant_q);
      req0_ready_o = idle & req0_valid_i & ~grant1;
      req1_ready_o = idle & grant1;
      hs           = req0_ready_o | req1_ready_o;
      sel_op       = grant1 ? req1_op_i : req0_op_i;
      sel_mask     = grant1 ? req1_mask_i : req0_mask_i;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (hs) begin
               state_d = StDrive;
            end
         end
`ifdef JK_SEQ_CHECK_EN
         StDrive: state_d = StCheck;
         StCheck: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
         default: state_d = StIdle;
`else
         StDrive: begin
            state_d = StIdle;
            done_d  = 1'b1;
         end
`endif
      endcase
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         j_q          <= '0;
         k_q          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         done_id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != StIdle);
         // Drive values are non-zero only for the single DRIVE cycle after a handshake.
         j_q     <= hs ? (sel_mask & {WIDTH{sel_op[1]}}) : '0;
         k_q     <= hs ? (sel_mask & {WIDTH{sel_op[0]}}) : '0;
         if (hs) begin
            id_q         <= grant1;
            last_grant_q <= grant1;
         end
         done_q <= done_d;
         if (done_d) begin
            done_id_q <= id_q;
         end
      end
   end

   assign j_o       = j_q;
   assign k_o       = k_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign done_id_o = done_id_q;

`ifdef JK_SEQ_CHECK_EN
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] result;
   logic             mismatch;
   logic             err_q;
   logic [7:0]       err_cnt_q;

   always_comb begin
      unique case (sel_op)
         2'b00:   result = q_i;
         2'b01:   result = '0;
         2'b10:   result = '1;
         default: result = ~q_i;
      endcase
      exp_d    = (q_i & ~sel_mask) | (sel_mask & result);
      mismatch = (state_q == StCheck) && (q_i != exp_q);
   end

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         exp_q     <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= 8'd0;
      end else begin
         if (hs) begin
            exp_q <= exp_d;
         end
         err_q <= mismatch;
         if (mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
         end
      end
   end

   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;
`else
   logic unused_q;
   assign unused_q  = ^q_i;
   assign err_o     = 1'b0;
   assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer with a behavioural JK bank and command model.
// Honours JK_SEQ_CHECK_EN the same way as the design.
module tb_jk_cmd_sequencer;

`ifdef JK_SEQ_CHECK_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       v0, v1, r0, r1;
   logic [1:0] op0, op1;
   logic [7:0] m0, m1;
   logic [7:0] q, j, k;
   logic       busy, done, done_id, err;
   logic [7:0] err_cnt;

   logic [7:0] bank;
   logic       bank_ld;
   logic [7:0] bank_ld_val;
   logic       force_en;
   logic [7:0] force_val;

   int errors = 0;
   int checks = 0;
   int model_errs = 0;

   always #5 clk = ~clk;

   jk_cmd_sequencer #(.WIDTH(8)) dut (
      .clk          (clk),
      .rst_ni       (rst_ni),
      .req0_valid_i (v0),
      .req0_op_i    (op0),
      .req0_mask_i  (m0),
      .req0_ready_o (r0),
      .req1_valid_i (v1),
      .req1_op_i    (op1),
      .req1_mask_i  (m1),
      .req1_ready_o (r1),
      .q_i          (q),
      .j_o          (j),
      .k_o          (k),
      .busy_o       (busy),
      .done_o       (done),
      .done_id_o    (done_id),
      .err_o        (err),
      .err_cnt_o    (err_cnt)
   );

   // JK bank: set on J-only, clear on K-only, toggle on both, hold otherwise.
   always @(posedge clk) begin
      if (bank_ld) bank <= bank_ld_val;
      else         bank <= (j & ~bank) | (~k & bank);
   end
   assign q = force_en ? force_val : bank;

   function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] mask,
                                           input logic [7:0] qv);
      case (op)
         2'd0:    return qv;
         2'd1:    return qv & ~mask;
         2'd2:    return qv | mask;
         default: return qv ^ mask;
      endcase
   endfunction

   task automatic clear_reqs();
      v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic set_bank(input logic [7:0] val);
      bank_ld = 1'b1; bank_ld_val = val;
      @(posedge clk); #1;
      bank_ld = 1'b0;
   endtask

   task automatic apply_reset();
      clear_reqs();
      rst_ni = 1'b0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      model_errs = 0;
   endtask

   task automatic issue(input int port, input logic [1:0] op, input logic [7:0] mask,
                        input bit corrupt);
      logic [7:0] qb, ex, exp_cnt;
      logic       rdy, other, exp_err;
      bit         got;
      if (port == 0) begin v0 = 1'b1; op0 = op; m0 = mask; end
      else           begin v1 = 1'b1; op1 = op; m1 = mask; end
      #1;
      got = 0;
      for (int i = 0; i < 8; i++) begin
         rdy = (port == 0) ? r0 : r1;
         if (rdy === 1'b1) begin got = 1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL issue_ready: port %0d ready never rose", port);
         clear_reqs();
         return;
      end
      other = (port == 0) ? r1 : r0;
      checks++;
      if (other !== 1'b0) begin
         errors++;
         $display("FAIL other_ready: got %b expected 0", other);
      end
      qb = q;
      ex = apply_op(op, mask, qb);
      @(posedge clk); #1;
      clear_reqs();
      checks++;
      if (j !== (mask & {8{op[1]}}) || k !== (mask & {8{op[0]}})) begin
         errors++;
         $display("FAIL drive_jk: got j=%h k=%h expected j=%h k=%h", j, k,
                  mask & {8{op[1]}}, mask & {8{op[0]}});
      end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL drive_status: got busy=%b done=%b expected 1 0", busy, done);
      end
      @(posedge clk); #1;
      checks++;
      if (q !== ex || j !== 8'h00 || k !== 8'h00) begin
         errors++;
         $display("FAIL bank_result: got q=%h j=%h k=%h expected q=%h j=0 k=0", q, j, k, ex);
      end
      exp_err = 1'b0;
`ifdef JK_SEQ_CHECK_EN
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL check_status: got busy=%b done=%b expected 1 0", busy, done);
      end
      if (corrupt) begin
         force_en = 1'b1; force_val = ~ex;
         model_errs++;
         exp_err = 1'b1;
      end
      @(posedge clk); #1;
      force_en = 1'b0;
`endif
      exp_cnt = (model_errs > 255) ? 8'd255 : 8'(model_errs);
      checks++;
      if (done !== 1'b1 || done_id !== port[0]) begin
         errors++;
         $display("FAIL done: got done=%b id=%b expected 1 %0d", done, done_id, port);
      end
      checks++;
      if (err !== exp_err || err_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL err: got err=%b cnt=%0d expected %b %0d", err, err_cnt, exp_err, exp_cnt);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_busy: got %b expected 0", busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got %b expected 0", done);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (j !== 8'h00 || k !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || done_id !== 1'b0 ||
          err !== 1'b0 || err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: got j=%h k=%h busy=%b done=%b id=%b err=%b cnt=%0d expected 0",
                  j, k, busy, done, done_id, err, err_cnt);
      end
      v0 = 1'b1; v1 = 1'b1; op0 = 2'd0; op1 = 2'd0; m0 = 8'h00; m1 = 8'h00;
      #1;
      checks++;
      if (r0 !== 1'b1 || r1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_tie: got r0=%b r1=%b expected 1 0", r0, r1);
      end
      clear_reqs();
      @(negedge clk);
      rst_ni = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      set_bank(8'h00);
      issue(0, 2'b10, 8'h0F, 0);
      set_bank(8'hAA);
      issue(1, 2'b11, 8'hFF, 0);
      issue(0, 2'b00, 8'hFF, 0);
      issue(1, 2'b10, 8'h00, 0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0) set_bank(8'($urandom));
         issue(int'($urandom_range(1)), 2'($urandom), 8'($urandom), 0);
      end
   endtask

   task automatic test_back_to_back();
      int  cnt;
      bit  last, w;
      int  due_c[$];
      bit  due_id[$];
      bit  exp_done;
      apply_reset();
      last = 1'b1;
      cnt = 0;
      v0 = 1'b1; v1 = 1'b1; op0 = 2'b01; op1 = 2'b01; m0 = 8'h01; m1 = 8'h01;
      #1;
      for (int c = 0; c < 30 + LAT; c++) begin
         if (c == 30) clear_reqs();
         #1;
         exp_done = (due_c.size() > 0) && (due_c[0] == c);
         checks++;
         if (done !== exp_done || (exp_done && done_id !== due_id[0])) begin
            errors++;
            $display("FAIL b2b_done c=%0d: got done=%b id=%b expected done=%b", c, done, done_id,
                     exp_done);
         end
         if (exp_done) begin void'(due_c.pop_front()); void'(due_id.pop_front()); end
         checks++;
         if (busy !== (cnt != 0)) begin
            errors++;
            $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy, cnt != 0);
         end
         if (cnt == 0 && c < 30) begin
            w = ~last;
            checks++;
            if (r0 !== ~w || r1 !== w) begin
               errors++;
               $display("FAIL b2b_grant c=%0d: got r0=%b r1=%b expected winner %0d", c, r0, r1, w);
            end
            last = w;
            cnt = LAT - 1;
            due_c.push_back(c + LAT);
            due_id.push_back(w);
         end else begin
            checks++;
            if (r0 !== 1'b0 || r1 !== 1'b0) begin
               errors++;
               $display("FAIL b2b_nogrant c=%0d: got r0=%b r1=%b expected 0 0", c, r0, r1);
            end
            if (cnt != 0) cnt--;
         end
         @(posedge clk);
      end
      #1;
   endtask

`ifdef JK_SEQ_CHECK_EN
   task automatic test_error_saturate();
      apply_reset();
      for (int n = 0; n < 300; n++) begin
         set_bank(8'h00);
         issue(0, 2'b10, 8'h80, 1);
      end
      issue(1, 2'b10, 8'h80, 0);
   endtask
`endif

   task automatic test_reset_mid();
      set_bank(8'h00);
      v0 = 1'b1; op0 = 2'b10; m0 = 8'hFF;
      #1;
      @(posedge clk); #1;
      clear_reqs();
      checks++;
      if (j !== 8'hFF) begin
         errors++;
         $display("FAIL mid_drive: got j=%h expected ff", j);
      end
      rst_ni = 1'b0;
      #1;
      checks++;
      if (j !== 8'h00 || k !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got j=%h k=%h busy=%b done=%b expected 0", j, k, busy, done);
      end
      model_errs = 0;
      @(posedge clk); #1;
      rst_ni = 1'b1;
      for (int c = 0; c < LAT + 1; c++) begin
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_nodone c=%0d: got done=%b busy=%b expected 0 0", c, done, busy);
         end
         @(posedge clk); #1;
      end
      v0 = 1'b1; v1 = 1'b1; op0 = 2'b00; op1 = 2'b00; m0 = 8'h00; m1 = 8'h00;
      #1;
      checks++;
      if (r0 !== 1'b1 || r1 !== 1'b0) begin
         errors++;
         $display("FAIL mid_tie: got r0=%b r1=%b expected 1 0", r0, r1);
      end
      @(posedge clk); #1;
      clear_reqs();
      repeat (LAT + 1) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_ni = 1'b0;
      clear_reqs();
      op0 = 2'd0; op1 = 2'd0; m0 = 8'h00; m1 = 8'h00;
      force_en = 1'b0; force_val = 8'h00;
      bank_ld = 1'b1; bank_ld_val = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      bank_ld = 1'b0;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
`ifdef JK_SEQ_CHECK_EN
      test_error_saturate();
`endif
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
